int_ctrl: RTL and testbench

INT_CTRL -- requirements
Module: int_ctrl

---
 rtl/int_ctrl.sv | 131 +++++++++++++
 tb/tb_int_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/int_ctrl.sv
// Six-line interrupt controller: MASK/PEND/STAT/EOI registers and a one-request-at-a-time IDLE/ASSERT/SERVICE handshake.
// Define INT_CTRL_EDGE_EN for rising-edge request capture; the default build captures requests by level.
module int_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  irq_in,
    input  logic [31:2] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    input  logic        ack,
    output logic [5:0]  HWInt
);

    localparam logic [1:0] IDLE    = 2'b00;
    localparam logic [1:0] ASSERT  = 2'b01;
    localparam logic [1:0] SERVICE = 2'b10;

    localparam logic [1:0] REG_MASK = 2'd0;
    localparam logic [1:0] REG_PEND = 2'd1;
    localparam logic [1:0] REG_STAT = 2'd2;
    localparam logic [1:0] REG_EOI  = 2'd3;

    logic [1:0] state, state_next;
    logic [2:0] id, id_next, low_id;
    logic [5:0] mask, mask_next;
    logic [5:0] pend, pend_sw, pend_next;
    logic [5:0] qual, req, id_onehot, ack_clr;
    logic       wr_mask, wr_pend, wr_eoi, keep, busy;
    logic       unused_bits;

    assign unused_bits = ^{Addr[31:4], Din[31:6]};

`ifdef INT_CTRL_EDGE_EN
    logic [5:0] irq_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) irq_prev <= '0;
        else       irq_prev <= irq_in;
    end

    assign qual = irq_in & ~irq_prev;
`else
    assign qual = irq_in;
`endif

    assign wr_mask = WE && (Addr[3:2] == REG_MASK);
    assign wr_pend = WE && (Addr[3:2] == REG_PEND);
    assign wr_eoi  = WE && (Addr[3:2] == REG_EOI);

    assign id_onehot = 6'd1 << id;
    assign mask_next = wr_mask ? Din[5:0] : mask;
    assign pend_sw   = pend & ~(wr_pend ? Din[5:0] : 6'd0);
    assign req       = pend & mask;

    // The asserted request survives only if it is still pending and unmasked after this cycle's writes.
    assign keep    = |((pend_sw | qual) & mask_next & id_onehot);
    assign ack_clr = (state == ASSERT && ack && keep) ? id_onehot : 6'd0;

    // New captures are OR-ed in last so a set beats any clear of the same bit.
    assign pend_next = (pend_sw & ~ack_clr) | qual;

    always_comb begin
        low_id = 3'd0;
        for (int i = 5; i >= 0; i--) begin
            if (req[i]) low_id = 3'(i);
        end
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        id_next    = id;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_next = ASSERT;
                    id_next    = low_id;
                end
            end
            ASSERT: begin
                if (!keep) begin
                    state_next = IDLE;
                    id_next    = 3'd0;
                end else if (ack) begin
                    state_next = SERVICE;
                end
            end
            SERVICE: begin
                if (wr_eoi) begin
                    state_next = IDLE;
                    id_next    = 3'd0;
                end
            end
            default: begin
                state_next = IDLE;
                id_next    = 3'd0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            id    <= 3'd0;
            mask  <= 6'h3F;
            pend  <= 6'd0;
        end else begin
            state <= state_next;
            id    <= id_next;
            mask  <= mask_next;
            pend  <= pend_next;
        end
    end

    // Decoded from state so an asynchronous reset removes the request without waiting for an edge.
    assign HWInt = (state == ASSERT) ? id_onehot : 6'd0;
    assign busy  = (state == ASSERT) || (state == SERVICE);

    always_comb begin
        Dout = 32'd0;
        case (Addr[3:2])
            REG_MASK: Dout = {26'd0, mask};
            REG_PEND: Dout = {26'd0, pend};
            REG_STAT: Dout = {busy, 26'd0, state, id};
            default:  Dout = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: expectations are queued as stimulus is applied and popped at each comparison.
module tb_int_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  irq_in;
    logic [31:2] addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;
    logic        ack;
    logic [5:0]  hwint;

    int n_assert = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] d;

    int_ctrl dut (
        .clk    (clk),
        .reset  (reset),
        .irq_in (irq_in),
        .Addr   (addr),
        .WE     (we),
        .Din    (din),
        .Dout   (dout),
        .ack    (ack),
        .HWInt  (hwint)
    );

    always #5 clk = ~clk;

    task automatic expect_v(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] exp_v;
        n_assert++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL %s observed=%h expected=<none queued>", tag, obs);
        end else begin
            exp_v = exp_q.pop_front();
            assert (obs === exp_v) else begin
                n_fail++;
                $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] sel, output logic [31:0] v);
        addr = {28'd0, sel};
        #1;
        v = dout;
    endtask

    task automatic wr(input logic [1:0] sel, input logic [31:0] v);
        addr = {28'd0, sel};
        din  = v;
        we   = 1'b1;
        step();
        we   = 1'b0;
    endtask

    task automatic chk_reg(input string tag, input logic [1:0] sel, input logic [31:0] v);
        expect_v(v);
        rd(sel, d);
        check(tag, d);
    endtask

    task automatic chk_hw(input string tag, input logic [5:0] v);
        expect_v({26'd0, v});
        check(tag, {26'd0, hwint});
    endtask

    initial begin
        reset = 1'b1; irq_in = '0; addr = '0; we = 1'b0; din = '0; ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_hw("rst_hwint", 6'd0);
        chk_reg("rst_mask", 2'd0, 32'h3F);
        chk_reg("rst_pend", 2'd1, 32'h0);
        chk_reg("rst_stat", 2'd2, 32'h0);
        reset = 1'b0;
        step();

        // Single pulse on line 2: PEND after one edge, HWInt after two, ack enters SERVICE.
        irq_in = 6'b000100;
        step();
        irq_in = 6'b000000;
        chk_reg("p2_pend", 2'd1, 32'h04);
        chk_hw("p2_hw_early", 6'd0);
        step();
        chk_hw("p2_hw", 6'b000100);
        chk_reg("p2_stat_assert", 2'd2, 32'h8000000A);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk_reg("p2_pend_ack", 2'd1, 32'h0);
        chk_reg("p2_stat_svc", 2'd2, 32'h80000012);
        chk_hw("p2_hw_svc", 6'd0);
        chk_reg("eoi_read", 2'd3, 32'h0);
        wr(2'd3, 32'h0);
        chk_reg("p2_stat_eoi", 2'd2, 32'h0);

        // Two simultaneous requests: lowest wins, the other follows after EOI.
        irq_in = 6'b000011;
        step();
        irq_in = 6'b000000;
        step();
        chk_hw("dual_hw0", 6'b000001);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk_reg("dual_pend", 2'd1, 32'h02);
        wr(2'd3, 32'h0);
        chk_hw("dual_hw_idle", 6'd0);
        step();
        chk_hw("dual_hw1", 6'b000010);

        // Software clears PEND[1] while asserted: back to IDLE, late ack ignored.
        wr(2'd1, 32'h02);
        chk_hw("cancel_hw", 6'd0);
        chk_reg("cancel_stat", 2'd2, 32'h0);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk_reg("idle_ack_stat", 2'd2, 32'h0);
        chk_reg("idle_ack_pend", 2'd1, 32'h0);

        // Masked request stays pending until unmasked.
        wr(2'd0, 32'h3E);
        chk_reg("mask_3e", 2'd0, 32'h3E);
        irq_in = 6'b000001;
        step();
        irq_in = 6'b000000;
        chk_reg("masked_pend", 2'd1, 32'h01);
        step();
        chk_hw("masked_hw", 6'd0);
        wr(2'd0, 32'h3F);
        step();
        chk_hw("unmask_hw", 6'b000001);

        // Masking the asserted line cancels it; PEND is kept.
        wr(2'd0, 32'h3E);
        chk_hw("mask_cancel_hw", 6'd0);
        chk_reg("mask_cancel_pend", 2'd1, 32'h01);
        wr(2'd0, 32'h3F);
        step();
        chk_hw("reassert_hw", 6'b000001);
        ack = 1'b1;
        step();
        ack = 1'b0;

        // SERVICE: no nesting, ack ignored, EOI outside SERVICE tested after reset.
        irq_in = 6'b000010;
        step();
        irq_in = 6'b000000;
        step();
        chk_hw("nest_hw", 6'd0);
        chk_reg("nest_stat", 2'd2, 32'h80000010);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk_reg("nest_pend", 2'd1, 32'h02);

        // Asynchronous reset in the middle of a SERVICE cycle.
        #2;
        reset = 1'b1;
        #1;
        chk_hw("arst_hw", 6'd0);
        chk_reg("arst_stat", 2'd2, 32'h0);
        chk_reg("arst_mask", 2'd0, 32'h3F);
        chk_reg("arst_pend", 2'd1, 32'h0);
        reset = 1'b0;
        step();
        wr(2'd3, 32'h0);
        chk_reg("eoi_idle_stat", 2'd2, 32'h0);

        // Held-high line 2 (masked to keep the FSM quiet), cleared by software at cycle 5.
        wr(2'd0, 32'h3B);
        irq_in = 6'b000100;
        step();
        chk_reg("hold_pend_set", 2'd1, 32'h04);
        repeat (3) step();
        wr(2'd1, 32'h04);
`ifdef INT_CTRL_EDGE_EN
        chk_reg("hold_pend_clr", 2'd1, 32'h0);
        repeat (5) step();
        chk_reg("hold_pend_end", 2'd1, 32'h0);
`else
        chk_reg("hold_pend_clr", 2'd1, 32'h04);
        repeat (5) step();
        chk_reg("hold_pend_end", 2'd1, 32'h04);
`endif
        irq_in = 6'b000000;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
